// File: rtl/cars_pkg.sv
// Shared constants for the traffic-lane motion block: lane geometry, timing, start positions.
// Pure declarations; no logic.
package cars_pkg;

    localparam int BLOCKSIZE = 32;

    localparam logic [2:0] SLOT_L4C0 = 3'd4;
    localparam logic [2:0] SLOT_L4C1 = 3'd5;
    localparam logic [2:0] SLOT_LAST = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

    // Slots 4 and 5 are both cars of lane 4; slot 6 is lane 5.
    function automatic logic [2:0] slot_lane(input logic [2:0] slot);
        case (slot)
            3'd5:    slot_lane = 3'd4;
            3'd6:    slot_lane = 3'd5;
            default: slot_lane = slot;
        endcase
    endfunction

    function automatic logic [9:0] lane_len(input logic [2:0] lane);
        case (lane)
            3'd1:    lane_len = 10'(2 * BLOCKSIZE);
            3'd3:    lane_len = 10'(3 * BLOCKSIZE);
            3'd5:    lane_len = 10'(2 * BLOCKSIZE);
            default: lane_len = 10'(BLOCKSIZE);
        endcase
    endfunction

    function automatic dir_e lane_dir(input logic [2:0] lane);
        case (lane)
            3'd1, 3'd3, 3'd5: lane_dir = DIR_RIGHT;
            default:          lane_dir = DIR_LEFT;
        endcase
    endfunction

    // Period minus one: the frame-counter value on which the lane moves.
    function automatic logic [1:0] lane_last(input logic [2:0] lane);
        case (lane)
            3'd1:    lane_last = 2'd1;
            3'd3:    lane_last = 2'd2;
            3'd4:    lane_last = 2'd1;
            default: lane_last = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] lane_base_step(input logic [2:0] lane);
        case (lane)
            3'd2, 3'd3: lane_base_step = 3'd2;
            default:    lane_base_step = 3'd1;
        endcase
    endfunction

    function automatic logic [9:0] init_x(input logic [2:0] slot);
        case (slot)
            3'd0:    init_x = 10'd200;
            3'd1:    init_x = 10'd300;
            3'd2:    init_x = 10'd400;
            3'd3:    init_x = 10'd150;
            3'd4:    init_x = 10'd120;
            3'd5:    init_x = 10'd344;
            default: init_x = 10'd250;
        endcase
    endfunction

endpackage

// File: rtl/cars_motion_if.sv
// Control inputs and per-vehicle position/length outputs of the lane motion block.
interface cars_motion_if;
    logic       frame_tick;
    logic       enable;
    logic       restart;
    logic [1:0] level;
    logic [9:0] lane0_car0_x;
    logic [9:0] lane1_car0_x;
    logic [9:0] lane2_car0_x;
    logic [9:0] lane3_car0_x;
    logic [9:0] lane4_car0_x;
    logic [9:0] lane4_car1_x;
    logic [9:0] lane5_car0_x;
    logic [9:0] lane0_length;
    logic [9:0] lane1_length;
    logic [9:0] lane2_length;
    logic [9:0] lane3_length;
    logic [9:0] lane4_length;
    logic [9:0] lane5_length;
    logic       update_done;

    modport master (
        output frame_tick, enable, restart, level,
        input  lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
               lane4_car0_x, lane4_car1_x, lane5_car0_x,
               lane0_length, lane1_length, lane2_length, lane3_length,
               lane4_length, lane5_length, update_done
    );

    modport slave (
        input  frame_tick, enable, restart, level,
        output lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
               lane4_car0_x, lane4_car1_x, lane5_car0_x,
               lane0_length, lane1_length, lane2_length, lane3_length,
               lane4_length, lane5_length, update_done
    );
endinterface

// File: rtl/cars_motion_lane_step.sv
// Next left-x of one vehicle, wrapping at the playfield edges.
// Latency: combinational.  Backpressure: none.
module lane_step
    import cars_pkg::*;
#(
    parameter int X_LEFT  = 96,
    parameter int X_RIGHT = 544
) (
    input  logic [9:0] x,
    input  logic [2:0] step,
    input  logic [9:0] length,
    input  dir_e       dir,
    output logic [9:0] nx
);

    logic [10:0] sum;
    logic [10:0] thresh;

    // 11-bit terms so neither the sum nor the left threshold can wrap.
    assign sum    = {1'b0, x} + {8'd0, step};
    assign thresh = 11'(X_LEFT) - {1'b0, length} + {8'd0, step};

    always_comb begin
        nx = x;
        if (dir == DIR_RIGHT) begin
            if (sum >= 11'(X_RIGHT)) nx = 10'(X_LEFT) - length;
            else                     nx = sum[9:0];
        end else begin
            if ({1'b0, x} < thresh)  nx = 10'(X_RIGHT);
            else                     nx = x - {7'd0, step};
        end
    end

endmodule

// File: rtl/cars_motion.sv
// Per-frame lane motion: updates seven vehicle positions one slot per cycle.
// Latency: slot k lands at end of cycle t+1+k after tick t; update_done in t+8.
// Backpressure: none; ticks outside IDLE are dropped.
module cars_motion
    import cars_pkg::*;
#(
    parameter int X_OFFSET_LEFT  = 96,
    parameter int X_OFFSET_RIGHT = 544
) (
    input  logic          clk,
    input  logic          reset_n,
    cars_motion_if.slave  bus
);

    state_e     state;
    logic [2:0] slot;
    logic [9:0] pos [7];
    logic [1:0] cnt [6];
    logic       move_l4;
    logic       update_done_q;

    logic [2:0] lane;
    logic [2:0] step;
    logic [9:0] cur_x;
    logic [9:0] nxt_x;
    logic [1:0] cur_cnt;
    logic       move_now;

    assign lane = slot_lane(slot);
    assign step = lane_base_step(lane) + {1'b0, bus.level};

    always_comb begin
        cur_x   = pos[6];
        cur_cnt = cnt[5];
        case (slot)
            3'd0: begin cur_x = pos[0]; cur_cnt = cnt[0]; end
            3'd1: begin cur_x = pos[1]; cur_cnt = cnt[1]; end
            3'd2: begin cur_x = pos[2]; cur_cnt = cnt[2]; end
            3'd3: begin cur_x = pos[3]; cur_cnt = cnt[3]; end
            3'd4: begin cur_x = pos[4]; cur_cnt = cnt[4]; end
            3'd5: begin cur_x = pos[5]; cur_cnt = cnt[4]; end
            default: ;
        endcase
    end

    // The second lane-4 car follows the first car's decision from the previous slot.
    assign move_now = (slot == SLOT_L4C1) ? move_l4 : (cur_cnt == lane_last(lane));

    lane_step #(
        .X_LEFT  (X_OFFSET_LEFT),
        .X_RIGHT (X_OFFSET_RIGHT)
    ) u_lane_step (
        .x      (cur_x),
        .step   (step),
        .length (lane_len(lane)),
        .dir    (lane_dir(lane)),
        .nx     (nxt_x)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            slot          <= 3'd0;
            move_l4       <= 1'b0;
            update_done_q <= 1'b0;
            for (int i = 0; i < 7; i++) pos[i] <= init_x(3'(i));
            for (int j = 0; j < 6; j++) cnt[j] <= 2'd0;
        end else if (bus.restart) begin
            state         <= IDLE;
            slot          <= 3'd0;
            move_l4       <= 1'b0;
            update_done_q <= 1'b0;
            for (int i = 0; i < 7; i++) pos[i] <= init_x(3'(i));
            for (int j = 0; j < 6; j++) cnt[j] <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    update_done_q <= 1'b0;
                    slot          <= 3'd0;
                    if (bus.frame_tick && bus.enable) state <= RUN;
                end
                RUN: begin
                    for (int i = 0; i < 7; i++)
                        if (move_now && slot == 3'(i)) pos[i] <= nxt_x;
                    if (slot != SLOT_L4C1)
                        for (int j = 0; j < 6; j++)
                            if (lane == 3'(j)) cnt[j] <= move_now ? 2'd0 : cnt[j] + 2'd1;
                    if (slot == SLOT_L4C0) move_l4 <= move_now;
                    if (slot == SLOT_LAST) begin
                        state         <= DONE;
                        slot          <= 3'd0;
                        update_done_q <= 1'b1;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
                DONE: begin
                    update_done_q <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    update_done_q <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.lane0_car0_x = pos[0];
    assign bus.lane1_car0_x = pos[1];
    assign bus.lane2_car0_x = pos[2];
    assign bus.lane3_car0_x = pos[3];
    assign bus.lane4_car0_x = pos[4];
    assign bus.lane4_car1_x = pos[5];
    assign bus.lane5_car0_x = pos[6];

    assign bus.lane0_length = lane_len(3'd0);
    assign bus.lane1_length = lane_len(3'd1);
    assign bus.lane2_length = lane_len(3'd2);
    assign bus.lane3_length = lane_len(3'd3);
    assign bus.lane4_length = lane_len(3'd4);
    assign bus.lane5_length = lane_len(3'd5);

    assign bus.update_done = update_done_q;

endmodule
